// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if
// Groups the requester, memory-read and write-through signals of the
// CPU/GPU memory read arbiter into one bundle.
//   slave  : the arbiter's view. It takes requests and memory responses,
//            and drives the acks, read data, memory strobes and timeout_err.
//   master : the environment's view. This is the CPU, GPU and memory side.
// Requester side : cpu_read/_addr/_data/_ack, gpu_read/_addr/_data/_ack
// Write channel  : cpu_write/_addr/_data -> mem_write/_addr/_data
// Memory side    : mem_read, mem_read_addr, mem_read_data, mem_read_ack
// Status         : timeout_err
interface mem_read_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
);
   logic              cpu_read;
   logic [ADDR_W-1:0] cpu_read_addr;
   logic [DATA_W-1:0] cpu_read_data;
   logic              cpu_read_ack;
   logic              gpu_read;
   logic [ADDR_W-1:0] gpu_read_addr;
   logic [DATA_W-1:0] gpu_read_data;
   logic              gpu_read_ack;
   logic              cpu_write;
   logic [ADDR_W-1:0] cpu_write_addr;
   logic [DATA_W-1:0] cpu_write_data;
   logic              mem_read;
   logic [ADDR_W-1:0] mem_read_addr;
   logic [DATA_W-1:0] mem_read_data;
   logic              mem_read_ack;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_write_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              timeout_err;

   modport slave (
      input  cpu_read, cpu_read_addr, gpu_read, gpu_read_addr,
      input  cpu_write, cpu_write_addr, cpu_write_data,
      input  mem_read_data, mem_read_ack,
      output cpu_read_data, cpu_read_ack, gpu_read_data, gpu_read_ack,
      output mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
      output timeout_err
   );

   modport master (
      output cpu_read, cpu_read_addr, gpu_read, gpu_read_addr,
      output cpu_write, cpu_write_addr, cpu_write_data,
      output mem_read_data, mem_read_ack,
      input  cpu_read_data, cpu_read_ack, gpu_read_data, gpu_read_ack,
      input  mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
      input  timeout_err
   );
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
// Shares one memory read port between the CPU and the GPU. Only one read is
// outstanding at a time. Grants use a round-robin pointer, and a watchdog
// force-completes a read if memory never answers. The CPU write channel
// passes straight through to memory. In IDLE, a CPU write blocks any read
// grant for that cycle, so a write is issued before a read in the same cycle.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_read_arbiter_if.slave (requesters, memory, write channel)
// Parameters: ADDR_W, DATA_W, TIMEOUT (max WAIT cycles, 1..65535)
module mem_read_arbiter #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst_n,
   mem_read_arbiter_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;   // 0 = CPU, 1 = GPU
   logic              prio_q, prio_d;     // 0 = CPU, 1 = GPU
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
   logic [DATA_W-1:0] gpu_data_q, gpu_data_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              gpu_ack_q, gpu_ack_d;
   logic              mem_rd_q, mem_rd_d;
   // timeout_err_q is high only in RESP, so it also serves as the timeout flag.
   logic              timeout_err_q, timeout_err_d;
   logic              grant_gpu_s;

   // Next-state logic: arbitration, read sequencing and the watchdog.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      prio_d        = prio_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      cpu_data_d    = cpu_data_q;
      gpu_data_d    = gpu_data_q;
      cpu_ack_d     = 1'b0;
      gpu_ack_d     = 1'b0;
      mem_rd_d      = 1'b0;
      timeout_err_d = 1'b0;
      // The GPU wins if it is the only requester, or if both request and the pointer names the GPU.
      grant_gpu_s   = bus.gpu_read && (!bus.cpu_read || prio_q);

      case (state_q)
         ST_IDLE: begin
            if ((bus.cpu_read || bus.gpu_read) && !bus.cpu_write) begin
               owner_d  = grant_gpu_s;
               addr_d   = grant_gpu_s ? bus.gpu_read_addr : bus.cpu_read_addr;
               mem_rd_d = 1'b1;
               state_d  = ST_ISSUE;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (bus.mem_read_ack) begin
               // Zero-latency memory may ack while still in ISSUE.
               if (owner_q) begin
                  gpu_data_d = bus.mem_read_data;
               end else begin
                  cpu_data_d = bus.mem_read_data;
               end
               cpu_ack_d = !owner_q;
               gpu_ack_d = owner_q;
               state_d   = ST_RESP;
            end else if (state_q == ST_ISSUE) begin
               cnt_d   = 16'd0;
               state_d = ST_WAIT;
            end else if (cnt_q == CNT_LAST) begin
               if (owner_q) begin
                  gpu_data_d = {DATA_W{1'b0}};
               end else begin
                  cpu_data_d = {DATA_W{1'b0}};
               end
               cpu_ack_d     = !owner_q;
               gpu_ack_d     = owner_q;
               timeout_err_d = 1'b1;
               state_d       = ST_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_RESP: begin
            prio_d  = !owner_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         owner_q       <= 1'b0;
         prio_q        <= 1'b0;
         addr_q        <= {ADDR_W{1'b0}};
         cnt_q         <= 16'd0;
         cpu_data_q    <= {DATA_W{1'b0}};
         gpu_data_q    <= {DATA_W{1'b0}};
         cpu_ack_q     <= 1'b0;
         gpu_ack_q     <= 1'b0;
         mem_rd_q      <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         prio_q        <= prio_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         cpu_data_q    <= cpu_data_d;
         gpu_data_q    <= gpu_data_d;
         cpu_ack_q     <= cpu_ack_d;
         gpu_ack_q     <= gpu_ack_d;
         mem_rd_q      <= mem_rd_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.cpu_read_data  = cpu_data_q;
   assign bus.cpu_read_ack   = cpu_ack_q;
   assign bus.gpu_read_data  = gpu_data_q;
   assign bus.gpu_read_ack   = gpu_ack_q;
   assign bus.mem_read       = mem_rd_q;
   assign bus.mem_read_addr  = addr_q;
   assign bus.timeout_err    = timeout_err_q;

   // The write channel is never stalled or reordered.
   assign bus.mem_write      = bus.cpu_write;
   assign bus.mem_write_addr = bus.cpu_write_addr;
   assign bus.mem_write_data = bus.cpu_write_data;
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter. The bench instantiates the DUT with TIMEOUT=8.
module tb_mem_read_arbiter;
   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   mem_lat;
   int   stray_cnt;

   typedef struct {
      bit         gpu;
      logic [7:0] data;
      bit         to;
      int         at;
   } ack_exp_t;

   typedef struct {
      logic [11:0] addr;
      int          at;
   } mem_exp_t;

   ack_exp_t ackq[$];
   mem_exp_t memq[$];

   mem_read_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus_if ();

   mem_read_arbiter #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [7:0] mem_val(input logic [11:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   // Memory model: acks mem_read after mem_lat cycles (-1 = never) and can emit stray acks.
   initial begin
      int          seen;
      logic [11:0] a;
      seen = 0;
      bus_if.mem_read_ack  = 1'b0;
      bus_if.mem_read_data = 8'h00;
      forever begin
         @(negedge clk);
         if (stray_cnt != seen) begin
            seen = stray_cnt;
            bus_if.mem_read_data = 8'hEE;
            bus_if.mem_read_ack  = 1'b1;
            @(negedge clk);
            bus_if.mem_read_ack  = 1'b0;
            bus_if.mem_read_data = 8'h00;
         end else if (bus_if.mem_read === 1'b1 && mem_lat >= 0) begin
            a = bus_if.mem_read_addr;
            repeat (mem_lat) @(negedge clk);
            bus_if.mem_read_data = mem_val(a);
            bus_if.mem_read_ack  = 1'b1;
            @(negedge clk);
            bus_if.mem_read_ack  = 1'b0;
            bus_if.mem_read_data = 8'h00;
         end
      end
   end

   // Monitor: pops and compares expected memory strobes and requester acks.
   initial begin
      mem_exp_t me;
      ack_exp_t ae;
      forever begin
         @(negedge clk);
         if (bus_if.mem_read === 1'b1) begin
            if (memq.size() == 0) begin
               chk("unexpected_mem_read", 32'd1, 32'd0);
            end else begin
               me = memq.pop_front();
               chk("mem_read_addr", 32'(bus_if.mem_read_addr), 32'(me.addr));
               chk("mem_read_cycle", 32'(cyc), 32'(me.at));
            end
         end
         if (bus_if.cpu_read_ack === 1'b1 && bus_if.gpu_read_ack === 1'b1) begin
            chk("both_acks", 32'd1, 32'd0);
         end else if (bus_if.cpu_read_ack === 1'b1 || bus_if.gpu_read_ack === 1'b1) begin
            if (ackq.size() == 0) begin
               chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
               ae = ackq.pop_front();
               chk("ack_owner_gpu", 32'(bus_if.gpu_read_ack), 32'(ae.gpu));
               chk("ack_data", ae.gpu ? 32'(bus_if.gpu_read_data) : 32'(bus_if.cpu_read_data), 32'(ae.data));
               chk("ack_timeout_err", 32'(bus_if.timeout_err), 32'(ae.to));
               chk("ack_cycle", 32'(cyc), 32'(ae.at));
            end
         end else if (bus_if.timeout_err === 1'b1) begin
            chk("timeout_err_without_ack", 32'd1, 32'd0);
         end
      end
   end

   task automatic push_mem(input logic [11:0] a, input int at);
      mem_exp_t e;
      e.addr = a;
      e.at   = at;
      memq.push_back(e);
   endtask

   task automatic push_ack(input bit gpu, input logic [7:0] d, input bit to, input int at);
      ack_exp_t e;
      e.gpu  = gpu;
      e.data = d;
      e.to   = to;
      e.at   = at;
      ackq.push_back(e);
   endtask

   task automatic wait_ack(input bit gpu);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         got = gpu ? (bus_if.gpu_read_ack === 1'b1) : (bus_if.cpu_read_ack === 1'b1);
         n   = n + 1;
      end
      if (!got) chk(gpu ? "wait_gpu_ack_timeout" : "wait_cpu_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_cpu_ack"}, 32'(bus_if.cpu_read_ack), 32'd0);
      chk({tag, "_gpu_ack"}, 32'(bus_if.gpu_read_ack), 32'd0);
      chk({tag, "_mem_read"}, 32'(bus_if.mem_read), 32'd0);
      chk({tag, "_mem_read_addr"}, 32'(bus_if.mem_read_addr), 32'd0);
      chk({tag, "_cpu_data"}, 32'(bus_if.cpu_read_data), 32'd0);
      chk({tag, "_gpu_data"}, 32'(bus_if.gpu_read_data), 32'd0);
      chk({tag, "_timeout_err"}, 32'(bus_if.timeout_err), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      int c;
      int r;
      n_checks  = 0;
      n_fail    = 0;
      mem_lat   = 1;
      stray_cnt = 0;
      rst_n     = 1'b0;
      bus_if.cpu_read       = 1'b0;
      bus_if.cpu_read_addr  = 12'h000;
      bus_if.gpu_read       = 1'b0;
      bus_if.gpu_read_addr  = 12'h000;
      bus_if.cpu_write      = 1'b0;
      bus_if.cpu_write_addr = 12'h000;
      bus_if.cpu_write_data = 8'h00;
      repeat (2) @(negedge clk);
      check_all_zero("por");
      rst_n = 1'b1;

      // CPU-only read, memory latency 1: mem_read at c+1, ack at c+3.
      @(posedge clk); #1;
      c = cyc;
      bus_if.cpu_read      = 1'b1;
      bus_if.cpu_read_addr = 12'h200;
      push_mem(12'h200, c + 1);
      push_ack(1'b0, 8'hA5, 1'b0, c + 3);
      wait_ack(1'b0);
      @(posedge clk); #1;
      bus_if.cpu_read = 1'b0;
      repeat (3) @(posedge clk);

      // Simultaneous requests after reset alternate CPU, GPU, CPU, GPU.
      do_reset();
      @(posedge clk); #1;
      c = cyc;
      bus_if.cpu_read      = 1'b1;
      bus_if.cpu_read_addr = 12'h200;
      bus_if.gpu_read      = 1'b1;
      bus_if.gpu_read_addr = 12'h050;
      push_mem(12'h200, c + 1);  push_ack(1'b0, 8'hA5, 1'b0, c + 3);
      push_mem(12'h050, c + 5);  push_ack(1'b1, 8'hF5, 1'b0, c + 7);
      push_mem(12'h200, c + 9);  push_ack(1'b0, 8'hA5, 1'b0, c + 11);
      push_mem(12'h050, c + 13); push_ack(1'b1, 8'hF5, 1'b0, c + 15);
      wait_ack(1'b0);
      wait_ack(1'b1);
      wait_ack(1'b0);
      wait_ack(1'b1);
      @(posedge clk); #1;
      bus_if.cpu_read = 1'b0;
      bus_if.gpu_read = 1'b0;
      @(negedge clk);
      chk("hold_cpu_data", 32'(bus_if.cpu_read_data), 32'h0A5);
      chk("hold_gpu_data", 32'(bus_if.gpu_read_data), 32'h0F5);
      repeat (2) @(posedge clk);

      // Timeout: memory never answers; forced ack with data 0 ten cycles after request.
      mem_lat = -1;
      @(posedge clk); #1;
      c = cyc;
      bus_if.cpu_read      = 1'b1;
      bus_if.cpu_read_addr = 12'h123;
      push_mem(12'h123, c + 1);
      push_ack(1'b0, 8'h00, 1'b1, c + 10);
      wait_ack(1'b0);
      @(posedge clk); #1;
      bus_if.cpu_read = 1'b0;
      stray_cnt = stray_cnt + 1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("stray_cpu_data", 32'(bus_if.cpu_read_data), 32'h000);
      chk("stray_gpu_data", 32'(bus_if.gpu_read_data), 32'h0F5);

      // Write interlock: write in the same cycle as a GPU read defers the grant one cycle.
      mem_lat = 1;
      @(posedge clk); #1;
      c = cyc;
      bus_if.cpu_write      = 1'b1;
      bus_if.cpu_write_addr = 12'h300;
      bus_if.cpu_write_data = 8'h12;
      bus_if.gpu_read       = 1'b1;
      bus_if.gpu_read_addr  = 12'h050;
      push_mem(12'h050, c + 2);
      push_ack(1'b1, 8'hF5, 1'b0, c + 4);
      @(negedge clk);
      chk("mem_write", 32'(bus_if.mem_write), 32'd1);
      chk("mem_write_addr", 32'(bus_if.mem_write_addr), 32'h300);
      chk("mem_write_data", 32'(bus_if.mem_write_data), 32'h012);
      @(posedge clk); #1;
      bus_if.cpu_write = 1'b0;
      wait_ack(1'b1);
      @(posedge clk); #1;
      bus_if.gpu_read = 1'b0;
      repeat (2) @(posedge clk);

      // Async reset while in WAIT; afterwards CPU priority is restored.
      mem_lat = -1;
      @(posedge clk); #1;
      c = cyc;
      bus_if.gpu_read      = 1'b1;
      bus_if.gpu_read_addr = 12'h050;
      push_mem(12'h050, c + 1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus_if.cpu_read      = 1'b1;
      bus_if.cpu_read_addr = 12'h200;
      #1;
      check_all_zero("async_reset");
      @(posedge clk);
      @(negedge clk);
      r = cyc;
      mem_lat = 1;
      rst_n = 1'b1;
      push_mem(12'h200, r + 1); push_ack(1'b0, 8'hA5, 1'b0, r + 3);
      push_mem(12'h050, r + 5); push_ack(1'b1, 8'hF5, 1'b0, r + 7);
      wait_ack(1'b0);
      @(posedge clk); #1;
      bus_if.cpu_read = 1'b0;
      wait_ack(1'b1);
      @(posedge clk); #1;
      bus_if.gpu_read = 1'b0;
      repeat (2) @(posedge clk);

      // Zero-latency memory: ack during ISSUE, requester ack at c+2.
      mem_lat = 0;
      @(posedge clk); #1;
      c = cyc;
      bus_if.cpu_read      = 1'b1;
      bus_if.cpu_read_addr = 12'h0FF;
      push_mem(12'h0FF, c + 1);
      push_ack(1'b0, 8'h5A, 1'b0, c + 2);
      wait_ack(1'b0);
      @(posedge clk); #1;
      bus_if.cpu_read = 1'b0;

      repeat (6) @(posedge clk);
      chk("ack_queue_drained", 32'(ackq.size()), 32'd0);
      chk("mem_queue_drained", 32'(memq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single memory read port between two requesters: the CPU (opcode/operand fetch) and the GPU (sprite-row fetch).
- Sits between cpu/gpu and memory. It sequences one outstanding read at a time, with round-robin fairness and a timeout watchdog.
- The CPU write channel passes straight through to the memory write port.

Parameters:
- ADDR_W, 12, memory address width
- DATA_W, 8, memory data width
- TIMEOUT, 255, max cycles in WAIT before a forced response (1..2^16-1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_read  in  1  CPU read request, level, held until cpu_read_ack
- cpu_read_addr  in  ADDR_W  CPU read address, stable while cpu_read=1
- cpu_read_data  out  DATA_W  read data, valid when cpu_read_ack=1
- cpu_read_ack  out  1  one-cycle completion pulse to CPU
- gpu_read  in  1  GPU read request, level, held until gpu_read_ack
- gpu_read_addr  in  ADDR_W  GPU read address
- gpu_read_data  out  DATA_W  read data, valid when gpu_read_ack=1
- gpu_read_ack  out  1  one-cycle completion pulse to GPU
- cpu_write  in  1  CPU write strobe
- cpu_write_addr  in  ADDR_W  CPU write address
- cpu_write_data  in  DATA_W  CPU write data
- mem_read  out  1  one-cycle read strobe to memory
- mem_read_addr  out  ADDR_W  registered read address
- mem_read_data  in  DATA_W  memory read data, valid with mem_read_ack
- mem_read_ack  in  1  memory completion pulse
- mem_write, mem_write_addr, mem_write_data  out  1/ADDR_W/DATA_W  combinational pass-through of cpu_write*
- timeout_err  out  1  one-cycle pulse when a read is force-completed

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all acks, mem_read and timeout_err are 0.
  - Data outputs and mem_read_addr are 0; the timeout counter is 0.
  - Priority pointer = CPU.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is pending and cpu_write=0, grant one requester.
  - Both requesting: grant the one named by the priority pointer.
  - Latch the granted address into mem_read_addr and the owner bit, then go to ISSUE.
  - If cpu_write=1, no grant that cycle (write-before-read ordering).
- ISSUE: mem_read=1 for exactly one cycle; counter cleared; go to WAIT. A mem_read_ack in ISSUE is accepted as in WAIT.
- WAIT:
  - On mem_read_ack: capture mem_read_data into the owner's data register, go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT-1 with no ack, load data 0, set the timeout flag, go to RESP.
- RESP:
  - Owner's read_ack=1 for one cycle; timeout_err=1 for the same cycle if the flag is set.
  - Priority pointer set to the non-owner; flag cleared; return to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_read at cycle 1.
  - If memory acks at cycle 1+L (L≥0), the requester ack comes at cycle 2+L.
  - With L=1, a request is served in 4 cycles. Minimum back-to-back read spacing is 4 cycles.
- Requester rules:
  - Drop the request in the cycle after ack, or it is treated as a new request on the next IDLE.
  - The address is sampled only at grant; changes afterwards are ignored.
- The non-owner's ack is never asserted. Its data register holds its last value.
- mem_read_ack in IDLE or RESP is ignored (stray or late ack). Memory must not ack after a timeout; this is a system constraint, not checked.
- Request dropped mid-transaction: the read still completes and the ack pulse is still issued; the requester ignores it.
- Reset mid-transaction: immediately return to IDLE; any in-flight memory response is ignored.
- Writes are never stalled. A write during WAIT is forwarded without ordering against the outstanding read.

Test Plan:
- CPU-only read: cpu_read=1 at 0x200; memory acks 1 cycle after mem_read with 0xA5 → mem_read_addr=0x200; mem_read at cycle 1; cpu_read_ack with cpu_read_data=0xA5 at cycle 3; gpu_read_ack stays 0.
- Simultaneous requests after reset: CPU at 0x200, GPU at 0x050 → CPU served first, then GPU. Keep both held continuously → the grants alternate CPU, GPU, CPU, GPU.
- Timeout with TIMEOUT=8: memory never acks → requester ack with data 0x00, timeout_err pulses together with it, 10 cycles after the request. Then feed a stray mem_read_ack → ignored.
- Write interlock: cpu_write=1 to 0x300=0x12 in the same cycle as gpu_read → mem_write mirrors the write in that cycle; GPU grant is deferred one cycle, so mem_read comes one cycle later.
- Async reset asserted in WAIT → all outputs 0 immediately and state IDLE. After release, a pending GPU request is re-served from scratch with CPU priority restored.
- Zero-latency memory (ack during ISSUE) → ack accepted; requester ack at cycle 2.
